// File: rtl/rice_bit_packer.sv
// rtl/rice_bit_packer.sv - Rice residual serialiser packing unary/stop/remainder bits into 16-bit words
//
// Purpose:
//   Takes one Rice-coded residual at a time (unary quotient q, stop+remainder
//   field, bit count). Emits q zeros, then the RICE_PARAM+1 bit tail MSB-first,
//   and packs the stream into 16-bit words (first bit in [15]). Keeps a
//   saturating total of the bit counts. A flush zero-pads and emits the last
//   partial word once every accepted residual has been packed.
//
// Ports:
//   iClock      in   1   clock, rising edge
//   iReset      in   1   synchronous, active-high reset
//   iValid      in   1   residual present this cycle
//   iMSB        in   16  unary quotient q
//   iLSB        in   16  [RICE_PARAM:0] = {stop bit, remainder}; upper bits ignored
//   iBitsUsed   in   16  residual length, only summed into oTotalBits
//   iFlush      in   1   pad/emit the partial word once idle
//   oReady      out  1   residual can be accepted this cycle
//   oWord       out  16  packed word
//   oValid      out  1   oWord strobe
//   oFlushDone  out  1   flush complete strobe
//   oTotalBits  out  32  saturating sum of accepted iBitsUsed
//   oOverflow   out  1   sticky: a residual was offered and dropped
//
// Optional build: RICE_PACK_FIFO_EN adds a FIFO_DEPTH-entry input FIFO.

module rice_bit_packer #(
  parameter int RICE_PARAM = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iValid,
  input  logic [15:0] iMSB,
  input  logic [15:0] iLSB,
  input  logic [15:0] iBitsUsed,
  input  logic        iFlush,
  output logic        oReady,
  output logic [15:0] oWord,
  output logic        oValid,
  output logic        oFlushDone,
  output logic [31:0] oTotalBits,
  output logic        oOverflow
);

  localparam int TW = RICE_PARAM + 1;

  typedef enum logic [1:0] {IDLE, ZEROS, TAIL, FLUSH} state_t;
  state_t state;

  logic [31:0]   acc;         // left-aligned pending bits
  logic [3:0]    fill;        // valid bits in acc[31 -: fill]
  logic [15:0]   q_rem;       // unary zeros still to emit
  logic [TW-1:0] lsb_r;       // tail of the residual in flight
  logic          flush_pend;

  // Residual source: either the ports directly or the FIFO head.
  logic          fsm_slot;    // FSM can start a new residual this cycle
  logic          take;        // FSM starts a residual this cycle
  logic          acc_in;      // a residual is accepted at the ports
  logic          drop;        // a residual is offered and lost
  logic          src_empty;   // nothing waiting in front of the FSM
  logic [15:0]   src_q;
  logic [TW-1:0] src_lsb;

  // iLSB bits above the tail field are don't-care by definition.
  logic unused_lsb;
  assign unused_lsb = ^iLSB;

  assign fsm_slot = (state == IDLE) || (state == TAIL);

`ifdef RICE_PACK_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [15:0]   fifo_q   [2**AW];
  logic [TW-1:0] fifo_lsb [2**AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;

  assign src_empty = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign oReady    = !full;
  assign acc_in    = iValid && !full;
  assign drop      = iValid && full;
  assign src_q     = fifo_q[rd_ptr[AW-1:0]];
  assign src_lsb   = fifo_lsb[rd_ptr[AW-1:0]];
  // The FSM keeps draining while a flush is pending; the flush itself
  // waits for the FIFO to run empty.
  assign take      = fsm_slot && !src_empty;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (acc_in) begin
        fifo_q[wr_ptr[AW-1:0]]   <= iMSB;
        fifo_lsb[wr_ptr[AW-1:0]] <= iLSB[RICE_PARAM:0];
        wr_ptr                   <= wr_ptr + (AW+1)'(1);
      end
      if (take) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end
`else
  assign oReady    = fsm_slot && !flush_pend;
  assign acc_in    = iValid && oReady;
  assign drop      = iValid && !oReady;
  assign take      = acc_in;
  assign src_empty = 1'b1;
  assign src_q     = iMSB;
  assign src_lsb   = iLSB[RICE_PARAM:0];
`endif

  // Bits appended this cycle: k zeros in ZEROS, the tail field in TAIL.
  logic        app_en;
  logic [4:0]  app_k;
  logic [31:0] app_pat;
  logic [31:0] acc_sum;
  logic [5:0]  fill_sum;
  logic [15:0] q_next;
  logic [32:0] tot_sum;

  always_comb begin
    app_en  = 1'b0;
    app_k   = '0;
    app_pat = '0;
    case (state)
      ZEROS: begin
        app_en = 1'b1;
        app_k  = (q_rem >= 16'd16) ? 5'd16 : q_rem[4:0];
      end
      TAIL: begin
        app_en  = 1'b1;
        app_k   = 5'(TW);
        app_pat = {lsb_r, {(32-TW){1'b0}}} >> fill;
      end
      default: ;
    endcase
  end

  // fill <= 15 and k <= 16, so fill_sum never reaches 32 and its low
  // nibble is the residual fill whether or not a word is retired.
  assign acc_sum  = acc | app_pat;
  assign fill_sum = {2'b00, fill} + {1'b0, app_k};
  assign q_next   = q_rem - {11'd0, app_k};
  assign tot_sum  = {1'b0, oTotalBits} + {17'd0, iBitsUsed};

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state      <= IDLE;
      acc        <= '0;
      fill       <= '0;
      q_rem      <= '0;
      lsb_r      <= '0;
      flush_pend <= 1'b0;
      oWord      <= '0;
      oValid     <= 1'b0;
      oFlushDone <= 1'b0;
      oTotalBits <= '0;
      oOverflow  <= 1'b0;
    end else begin
      oValid     <= 1'b0;
      oFlushDone <= 1'b0;

      if (drop) begin
        oOverflow <= 1'b1;
      end
      if (acc_in) begin
        oTotalBits <= tot_sum[32] ? 32'hFFFF_FFFF : tot_sum[31:0];
      end

      // Repeated flush requests before completion collapse into one.
      if (state == FLUSH) begin
        flush_pend <= 1'b0;
      end else if (iFlush) begin
        flush_pend <= 1'b1;
      end

      if (app_en) begin
        if (fill_sum[4]) begin
          oWord  <= acc_sum[31:16];
          oValid <= 1'b1;
          acc    <= {acc_sum[15:0], 16'h0000};
        end else begin
          acc <= acc_sum;
        end
        fill <= fill_sum[3:0];
      end

      case (state)
        IDLE: begin
          if (take) begin
            q_rem <= src_q;
            lsb_r <= src_lsb;
            state <= (src_q != 16'd0) ? ZEROS : TAIL;
          end else if ((flush_pend || iFlush) && src_empty) begin
            state <= FLUSH;
          end
        end
        ZEROS: begin
          q_rem <= q_next;
          if (q_next == 16'd0) begin
            state <= TAIL;
          end
        end
        TAIL: begin
          // Overlapping the next accept with this tail gives one
          // residual per cycle when q = 0.
          if (take) begin
            q_rem <= src_q;
            lsb_r <= src_lsb;
            state <= (src_q != 16'd0) ? ZEROS : TAIL;
          end else begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (fill != 4'd0) begin
            oWord  <= acc[31:16];
            oValid <= 1'b1;
          end
          oFlushDone <= 1'b1;
          acc        <= '0;
          fill       <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
